// File: rtl/sram_pipe.sv
// sram_pipe: single-port synchronous data RAM with valid/ready request and
// response channels, byte-strobed writes, range checking and an in-order
// response FIFO that absorbs consumer backpressure.
module sram_pipe #(
    parameter int          DATA_W    = 64,
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W/8-1:0] req_we,
    input  logic [63:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_wr,
    output logic                resp_err
);

    localparam int NB   = DATA_W / 8;
    localparam int OFFW = (NB > 1) ? $clog2(NB) : 1;
    localparam int SHW  = $clog2(NB);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FD   = RD_LAT + 1;          // response FIFO depth
    localparam int FAW  = $clog2(FD);          // FD >= 2, so FAW >= 1
    localparam int CW   = $clog2(RD_LAT + 2);  // outstanding counter width
    localparam int STG  = RD_LAT - 1;          // register stages before FIFO

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              wr;
        logic              err;
    } resp_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [63:0]   off, idx;
    logic [AW-1:0] widx;
    logic          err, is_wr, acc, pop, push_vld;
    resp_t         s0, push_dat, head;

    // address decode: low byte-offset bits are dropped, range checked on word index
    assign off   = req_addr - BASE_ADDR;
    assign idx   = off >> SHW;
    assign err   = (req_addr < BASE_ADDR) || (idx >= 64'(DEPTH));
    assign widx  = idx[AW-1:0];
    assign is_wr = |req_we;
    assign acc   = req_valid & req_ready;

    // response word formed at the accept edge; writes and errors carry zero data
    always_comb begin
        s0       = '0;
        s0.wr    = is_wr;
        s0.err   = err;
        s0.rdata = (!err && !is_wr) ? mem[widx] : '0;
    end

    // byte-strobed write; req_ready is low during reset so nothing commits then
    always_ff @(posedge clk) begin
        if (acc && is_wr && !err) begin
            for (int b = 0; b < NB; b++) begin
                if (req_we[b]) mem[widx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end

    generate
        if (STG == 0) begin : g_nostg
            assign push_vld = acc;
            assign push_dat = s0;
        end else begin : g_stg
            logic [STG-1:0] vld_pipe;
            resp_t          stg_q [STG];

            // fixed-latency shift of sampled responses towards the FIFO
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    for (int k = 0; k < STG; k++) stg_q[k] <= '0;
                end else begin
                    for (int k = 0; k < STG; k++) begin
                        if (k == 0) begin
                            vld_pipe[k] <= acc;
                            stg_q[k]    <= s0;
                        end else begin
                            vld_pipe[k] <= vld_pipe[k-1];
                            stg_q[k]    <= stg_q[k-1];
                        end
                    end
                end
            end

            assign push_vld = vld_pipe[STG-1];
            assign push_dat = stg_q[STG-1];
        end
    endgenerate

    // ---------------- response FIFO ----------------
    resp_t          fifo [FD];
    logic [FAW:0]   wp, rp;
    logic           empty;

    // index wraps at FD (not necessarily a power of two); MSB flips on wrap
    function automatic logic [FAW:0] ptr_inc(input logic [FAW:0] p);
        if (p[FAW-1:0] == FAW'(FD - 1)) return {~p[FAW], FAW'(0)};
        else                            return p + 1'b1;
    endfunction

    assign empty = (wp == rp);
    assign pop   = resp_valid & resp_ready;
    assign head  = fifo[rp[FAW-1:0]];

    // FIFO pointers; overflow is impossible because the outstanding limit equals FD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_vld) wp <= ptr_inc(wp);
            if (pop)      rp <= ptr_inc(rp);
        end
    end

    // FIFO storage; contents are only visible while non-empty
    always_ff @(posedge clk) begin
        if (push_vld) fifo[wp[FAW-1:0]] <= push_dat;
    end

    assign resp_valid = ~empty;
    assign resp_rdata = empty ? '0 : head.rdata;
    assign resp_wr    = empty ? 1'b0 : head.wr;
    assign resp_err   = empty ? 1'b0 : head.err;

    // ---------------- outstanding tracking ----------------
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rdy_q;

    // next outstanding count from this cycle's accept and response handshake
    always_comb begin
        cnt_nxt = cnt + CW'(acc) - CW'(pop);
    end

    // ready is registered so resp_ready never reaches req_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rdy_q <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt < CW'(RD_LAT + 1));
        end
    end

    assign req_ready = rdy_q;

    // keep OFFW referenced for narrow configurations
    logic unused_ok;
    assign unused_ok = (OFFW > 0);

endmodule

// File: tb/tb_sram_pipe.sv
// Bench for sram_pipe: three instances (RD_LAT 1, 3, 2) checked every cycle
// against a word-array plus expected-response-queue model.
module tb_sram_pipe;

    localparam int          DEPTH = 64;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rv [3];
    logic        rr [3];
    logic [7:0]  rwe [3];
    logic [63:0] raddr [3];
    logic [63:0] rwd [3];
    logic        sv [3];
    logic        sr [3];
    logic [63:0] rdat [3];
    logic        swr [3];
    logic        serr [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_pipe #(
            .DATA_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE),
            .RD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 2))
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(rv[g]), .req_ready(rr[g]), .req_we(rwe[g]),
            .req_addr(raddr[g]), .req_wdata(rwd[g]),
            .resp_valid(sv[g]), .resp_ready(sr[g]), .resp_rdata(rdat[g]),
            .resp_wr(swr[g]), .resp_err(serr[g])
        );
    end

    typedef struct {
        logic [63:0] rdata;
        bit          wr;
        bit          err;
        int          due;
    } exp_t;

    logic [63:0] mm [3][DEPTH];
    exp_t        q  [3][$];
    bit          last_acc [3];
    int          dut_acc [3];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic int lat(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(int i, logic v, logic [7:0] w, logic [63:0] a, logic [63:0] d);
        rv[i] = v; rwe[i] = w; raddr[i] = a; rwd[i] = d;
    endtask

    // one clock: compare outputs to the model at the falling edge, then advance
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bit   mrdy, ev, er;
            exp_t e;
            int   w;
            mrdy = (q[i].size() < lat(i) + 1);
            ev   = (q[i].size() > 0) && (q[i][0].due <= cyc);
            check($sformatf("req_ready[%0d] c%0d", i, cyc), 64'(rr[i]), 64'(mrdy));
            check($sformatf("resp_valid[%0d] c%0d", i, cyc), 64'(sv[i]), 64'(ev));
            if (ev) begin
                check($sformatf("rdata[%0d] c%0d", i, cyc), rdat[i], q[i][0].rdata);
                check($sformatf("wr[%0d] c%0d", i, cyc), 64'(swr[i]), 64'(q[i][0].wr));
                check($sformatf("err[%0d] c%0d", i, cyc), 64'(serr[i]), 64'(q[i][0].err));
                if (sr[i]) void'(q[i].pop_front());
            end
            if (rv[i] && rr[i]) dut_acc[i]++;
            last_acc[i] = rv[i] && mrdy;
            if (last_acc[i]) begin
                er      = (raddr[i] < BASE) || (raddr[i] >= BASE + 64'(DEPTH) * 8);
                e.wr    = (rwe[i] != 8'h00);
                e.err   = er;
                e.rdata = '0;
                e.due   = cyc + lat(i);
                if (!er) begin
                    w = int'((raddr[i] - BASE) / 8);
                    if (e.wr) begin
                        for (int b = 0; b < 8; b++)
                            if (rwe[i][b]) mm[i][w][b*8 +: 8] = rwd[i][b*8 +: 8];
                    end else begin
                        e.rdata = mm[i][w];
                    end
                end
                q[i].push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // present a request and hold it until the model says it was taken
    task automatic send(int i, logic [7:0] w, logic [63:0] a, logic [63:0] d);
        int n = 0;
        drive(i, 1'b1, w, a, d);
        do begin
            tick();
            n++;
        end while (!last_acc[i] && n < 40);
        if (!last_acc[i]) begin
            errors++;
            $error("FAIL send[%0d]: request not accepted within 40 cycles", i);
        end
    endtask

    task automatic drain();
        int n = 0;
        for (int i = 0; i < 3; i++) rv[i] = 1'b0;
        while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < 60) begin
            tick();
            n++;
        end
        if ((q[0].size() + q[1].size() + q[2].size()) > 0) begin
            errors++;
            $error("FAIL drain: %0d responses missing after 60 cycles",
                   q[0].size() + q[1].size() + q[2].size());
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int c0, acc0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 8'h00, BASE, '0);
            sr[i] = 1'b1;
            dut_acc[i] = 0;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst resp_valid[%0d]", i), 64'(sv[i]), 64'd0);
            check($sformatf("rst resp_rdata[%0d]", i), rdat[i], 64'd0);
            check($sformatf("rst resp_wr[%0d]", i), 64'(swr[i]), 64'd0);
            check($sformatf("rst resp_err[%0d]", i), 64'(serr[i]), 64'd0);
        end
        release_reset();

        // fill every word of every instance with random data
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < DEPTH; w++)
                send(i, 8'hFF, BASE + 64'(w) * 8, {$urandom, $urandom});
            drain();
        end

        // RD_LAT=1: full write then read-back, then byte-masked overwrite
        send(0, 8'hFF, BASE, 64'h1122334455667788);
        send(0, 8'h00, BASE, '0);
        drain();
        send(0, 8'h0F, BASE, 64'hAAAAAAAA_BBBBBBBB);
        send(0, 8'h00, BASE + 3, '0);
        drain();

        // out of range below and above, an ignored write, then word 0 again
        send(0, 8'h00, BASE - 8, '0);
        send(0, 8'h00, BASE + 64'(DEPTH) * 8, '0);
        send(0, 8'hFF, BASE + 64'(DEPTH) * 8 + 16, 64'hDEAD_BEEF_0000_0001);
        send(0, 8'h00, BASE, '0);
        drain();

        // random traffic with random consumer stalls
        for (int n = 0; n < 80; n++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 9) == 0) ? BASE - 64'($urandom_range(1, 64))
                : BASE + 64'($urandom_range(0, DEPTH + 3)) * 8 + 64'($urandom_range(0, 7));
            sr[0] = ($urandom_range(0, 3) != 0);
            sr[2] = ($urandom_range(0, 2) != 0);
            drive(0, 1'b1, ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00, a, {$urandom, $urandom});
            drive(2, $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                  BASE + 64'($urandom_range(0, DEPTH - 1)) * 8, {$urandom, $urandom});
            tick();
        end
        sr[0] = 1'b1;
        sr[2] = 1'b1;
        drain();

        // RD_LAT=3 throughput: ramp, then 16 back-to-back reads
        for (int k = 0; k < 16; k++)
            send(1, 8'hFF, BASE + 64'(k) * 8, 64'(k) * 64'h0101_0101_0101_0101);
        drain();
        c0 = cyc;
        dut_acc[1] = 0;
        for (int k = 0; k < 16; k++) send(1, 8'h00, BASE + 64'(k) * 8, '0);
        check("burst cycles", 64'(cyc - c0), 64'd16);
        check("burst accepts", 64'(dut_acc[1]), 64'd16);
        drain();

        // RD_LAT=2 backpressure: consumer stalled for 10 cycles
        sr[2] = 1'b0;
        dut_acc[2] = 0;
        for (int n = 0; n < 10; n++) begin
            drive(2, 1'b1, 8'h00, BASE + 64'($urandom_range(0, DEPTH - 1)) * 8, '0);
            tick();
        end
        check("bp accepts", 64'(dut_acc[2]), 64'd3);
        check("bp req_ready", 64'(rr[2]), 64'd0);
        acc0 = dut_acc[2];
        sr[2] = 1'b1;
        drain();
        send(2, 8'h00, BASE + 8, '0);
        send(2, 8'h00, BASE + 16, '0);
        check("bp resumed", 64'(dut_acc[2] - acc0), 64'd2);
        drain();

        // async reset between edges while a write is being presented
        send(0, 8'hFF, BASE + 5 * 8, 64'h5555_AAAA_1234_5678);
        drive(0, 1'b1, 8'hFF, BASE + 6 * 8, 64'h6666_BBBB_8765_4321);
        check("pre-rst resp_valid", 64'(sv[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async rst resp_valid[%0d]", i), 64'(sv[i]), 64'd0);
            check($sformatf("async rst resp_rdata[%0d]", i), rdat[i], 64'd0);
            q[i].delete();
        end
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) rv[i] = 1'b0;
        release_reset();
        tick();
        send(0, 8'h00, BASE + 5 * 8, '0);
        send(0, 8'h00, BASE + 6 * 8, '0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
